edge_event_capture: RTL
=======================

EDGE_EVENT_CAPTURE -- requirements
Module: edge_event_capture

Interface
REQ-001 Parameter WIDTH, default 4, number of independent input channels (legal range 1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops per channel (legal range 2..4).
REQ-003 Parameter FILTER_LEN, default 4, cycles a synchronised level must hold before acceptance (legal range 1..65535).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 sig_in  input  WIDTH  asynchronous level inputs, one bit per channel.
REQ-008 mode  input  2*WIDTH  per-channel capture mode; bits [2i+1:2i] belong to channel i (00 off, 01 rising, 10 falling, 11 both).
REQ-009 clr  input  WIDTH  per-channel clear strobe for pending[i] and overflow[i].
REQ-010 rise  output  WIDTH  one-cycle pulse on an accepted 0->1 transition, independent of mode.
REQ-011 fall  output  WIDTH  one-cycle pulse on an accepted 1->0 transition, independent of mode.
REQ-012 pending  output  WIDTH  sticky flag; channel i has a mode-enabled event awaiting clear.
REQ-013 overflow  output  WIDTH  sticky flag; an enabled event arrived while pending[i] was already set.
REQ-014 irq  output  1  OR of all pending bits.

Function
REQ-015 Each channel SHALL pass sig_in[i] through a chain of SYNC_STAGES flops; s[i] is the last stage.
REQ-016 Each channel SHALL hold an accepted level filt[i] and a counter cnt[i] of width $clog2(FILTER_LEN+1).
REQ-017 While s[i]==filt[i], cnt[i] SHALL be 0 on the next cycle.
REQ-018 While s[i]!=filt[i] and cnt[i]<FILTER_LEN-1, cnt[i] SHALL increment.
REQ-019 While s[i]!=filt[i] and cnt[i]==FILTER_LEN-1, filt[i] SHALL take s[i] and cnt[i] SHALL return to 0.
REQ-020 rise[i] SHALL be registered and high for exactly the cycle in which filt[i] first reads 1 after reading 0; fall[i] likewise for 1->0.
REQ-021 Latency: if sig_in[i] changes and holds, rise[i] or fall[i] SHALL be high after the (SYNC_STAGES+FILTER_LEN)-th clk edge, counting the first edge that samples the new level as edge 1.
REQ-022 Glitch rejection: an s[i] excursion lasting fewer than FILTER_LEN cycles SHALL produce no rise or fall and SHALL leave filt[i] unchanged.
REQ-023 An enabled event is rise[i] with mode bit 2i set, or fall[i] with mode bit 2i+1 set; mode 00 SHALL never set any flag.
REQ-024 An enabled event SHALL set pending[i] on the following edge.
REQ-025 clr[i] without a simultaneous enabled event SHALL clear pending[i] and overflow[i] on the following edge.
REQ-026 clr[i] and an enabled event in the same cycle: pending[i] SHALL end at 1 (set wins), and overflow[i] SHALL end at 0.
REQ-027 An enabled event while pending[i]=1 and clr[i]=0 SHALL set overflow[i]; overflow[i] SHALL hold until cleared.
REQ-028 Changing mode SHALL affect only events occurring in that same cycle or later; it SHALL NOT alter existing flags.
REQ-029 irq SHALL be combinational |pending with no extra latency.
REQ-030 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be captured.

Reset
REQ-031 While rst=1 at a clk edge, all sync flops, filt, cnt, rise, fall, pending and overflow SHALL become 0, and irq SHALL read 0.
REQ-032 rst SHALL override clr and any in-flight filter count; a partially qualified transition SHALL be discarded.
REQ-033 filt resets to 0, so a channel held high through reset release SHALL report rise after the REQ-021 latency.

Verification (WIDTH=4, SYNC_STAGES=2, FILTER_LEN=4)
REQ-034 Step: sig_in[0] 0->1 and hold, mode[1:0]=01 -> rise[0] is a single pulse after edge 6, then pending[0]=1 and irq=1; fall[0] stays 0.
REQ-035 Glitch: sig_in[1] high for 3 cycles, mode=11 -> rise, fall, pending[1] and cnt[1] stay 0 or return to 0; a 4-cycle pulse yields rise then fall.
REQ-036 Overflow: two enabled rises on channel 2 without clr -> pending[2]=1 and overflow[2]=1; clr[2] for one cycle -> both 0 and irq=0.
REQ-037 Collision: clr[3] asserted in the same cycle as an enabled fall on channel 3 with pending[3]=1 -> pending[3]=1 and overflow[3]=0.
REQ-038 Reset: assert rst mid-count (cnt=2) with sig_in=all 1s, then release -> all outputs 0 during reset, and rise on all four channels after edge 6.
REQ-039 Mode off: mode=00 on all channels with toggling inputs -> rise and fall pulse as normal, while pending, overflow and irq stay 0.

Source files
------------

// File: rtl/edge_event_capture_if.sv
// Bundles the per-channel level inputs, mode/clear controls and event flags.
// The master side drives levels and controls; the slave side is the capture block.
interface edge_event_capture_if #(
   parameter int WIDTH = 4
);

   logic [WIDTH-1:0]   sig_in;
   logic [2*WIDTH-1:0] mode;
   logic [WIDTH-1:0]   clr;
   logic [WIDTH-1:0]   rise;
   logic [WIDTH-1:0]   fall;
   logic [WIDTH-1:0]   pending;
   logic [WIDTH-1:0]   overflow;
   logic               irq;

   modport master (
      output sig_in, mode, clr,
      input  rise, fall, pending, overflow, irq
   );

   modport slave (
      input  sig_in, mode, clr,
      output rise, fall, pending, overflow, irq
   );

endinterface

// File: rtl/edge_event_capture.sv
// Multi-channel edge event capture.
// Each channel synchronises an asynchronous level, debounces it with a
// hold-time filter, emits rise/fall pulses on accepted transitions and
// latches mode-selected events into sticky pending/overflow flags.
module edge_event_capture #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   edge_event_capture_if.slave  bus
);

   localparam int             CNT_W    = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [WIDTH-1:0] rise_v;
   logic [WIDTH-1:0] fall_v;
   logic [WIDTH-1:0] pend_v;
   logic [WIDTH-1:0] ovf_v;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CNT_W-1:0]       cnt_q;
      logic                   filt_q;
      logic                   rise_q;
      logic                   fall_q;
      logic                   pend_q;
      logic                   ovf_q;
      logic                   s;
      logic                   accept;
      logic                   event_en;

      // Synchroniser chain: bring the asynchronous level into the clk domain.
      always_ff @(posedge clk) begin
         // NOTE: all state uses non-blocking assignment so every flop samples
         // the pre-edge value of its neighbours, giving a true shift chain.
         if (rst) sync_q <= '0;
         else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in[i]};
      end

      assign s        = sync_q[SYNC_STAGES-1];
      assign accept   = (s != filt_q) && (cnt_q == CNT_LAST);
      assign event_en = (rise_q && bus.mode[2*i]) || (fall_q && bus.mode[2*i+1]);

      // Hold-time filter: a new level is accepted only after FILTER_LEN
      // consecutive cycles of disagreement; the edge pulses are registered
      // alongside the accepted level so they line up with its change.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else if (s == filt_q) begin
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else if (accept) begin
            cnt_q  <= '0;
            filt_q <= s;
            rise_q <= s;
            fall_q <= ~s;
         end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end
      end

      // Sticky flags: a new event beats a clear for pending, while a clear
      // in the same cycle still drops any prior overflow.
      always_ff @(posedge clk) begin
         if (rst) begin
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
         end else if (event_en) begin
            pend_q <= 1'b1;
            ovf_q  <= bus.clr[i] ? 1'b0 : (ovf_q | pend_q);
         end else if (bus.clr[i]) begin
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
         end
      end

      assign rise_v[i] = rise_q;
      assign fall_v[i] = fall_q;
      assign pend_v[i] = pend_q;
      assign ovf_v[i]  = ovf_q;
   end

   assign bus.rise     = rise_v;
   assign bus.fall     = fall_v;
   assign bus.pending  = pend_v;
   assign bus.overflow = ovf_v;
   assign bus.irq      = |pend_v;

endmodule
